// File: rtl/regfile_stack_ctrl.sv
// Push/pop sequencer for the stacked register-file instances: tracks nesting depth,
// issues a one-cycle command pulse per legal request and keeps sticky overflow/underflow flags.
package RegFilePkg;
   typedef enum logic [1:0] {
      Command_none = 2'd0,
      Command_push = 2'd1,
      Command_pop  = 2'd2
   } Command;
endpackage

module regfile_stack_ctrl #(
   parameter int DEPTH = 4,
   localparam int DW = $clog2(DEPTH + 1)
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_req_valid,
   input  logic               i_req_pop,
   output logic               o_req_ready,
   output RegFilePkg::Command o_command,
   output logic [DW-1:0]      o_depth,
   output logic [DEPTH-1:0]   o_level_valid,
   output logic               o_full,
   output logic               o_empty,
   output logic               o_overflow,
   output logic               o_underflow,
   input  logic               i_err_clr
);
   import RegFilePkg::*;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   localparam logic [DW-1:0] DEPTH_C = DW'(DEPTH);
   localparam logic [DW-1:0] ZERO_C  = {DW{1'b0}};
   localparam logic [DW-1:0] ONE_C   = DW'(1);

   state_t          state_r, state_s;
   Command          command_r, command_s;
   logic [DW-1:0]   depth_r, depth_s;
   logic            overflow_r, overflow_s;
   logic            underflow_r, underflow_s;
   logic            handshake_s, push_ok_s, pop_ok_s, push_err_s, pop_err_s;
   logic [DEPTH-1:0] level_s;

   // Classify the request presented this cycle; illegal ones are still consumed.
   always_comb begin
      handshake_s = i_req_valid & (state_r == IDLE);
      push_ok_s   = handshake_s & ~i_req_pop & (depth_r != DEPTH_C);
      pop_ok_s    = handshake_s &  i_req_pop & (depth_r != ZERO_C);
      push_err_s  = handshake_s & ~i_req_pop & (depth_r == DEPTH_C);
      pop_err_s   = handshake_s &  i_req_pop & (depth_r == ZERO_C);
   end

   // Next-state, next-command, depth and sticky-flag logic.
   always_comb begin
      state_s     = state_r;
      command_s   = Command_none;
      depth_s     = depth_r;
      overflow_s  = overflow_r;
      underflow_s = underflow_r;
      case (state_r)
         IDLE: begin
            if (push_ok_s) begin
               state_s   = ISSUE;
               command_s = Command_push;
               depth_s   = depth_r + ONE_C;
            end else if (pop_ok_s) begin
               state_s   = ISSUE;
               command_s = Command_pop;
               depth_s   = depth_r - ONE_C;
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      // A new error in the same cycle as a clear wins.
      if (push_err_s) begin
         overflow_s = 1'b1;
      end else if (i_err_clr) begin
         overflow_s = 1'b0;
      end else begin
         overflow_s = overflow_r;
      end
      if (pop_err_s) begin
         underflow_s = 1'b1;
      end else if (i_err_clr) begin
         underflow_s = 1'b0;
      end else begin
         underflow_s = underflow_r;
      end
   end

   // State, command and depth registers.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_r     <= IDLE;
         command_r   <= Command_none;
         depth_r     <= ZERO_C;
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         command_r   <= command_s;
         depth_r     <= depth_s;
         overflow_r  <= overflow_s;
         underflow_r <= underflow_s;
      end
   end

   // Thermometer map: level k is occupied while k is below the depth.
   always_comb begin
      level_s = {DEPTH{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
         if (k < int'(depth_r)) begin
            level_s[k] = 1'b1;
         end else begin
            level_s[k] = 1'b0;
         end
      end
   end

   assign o_req_ready   = (state_r == IDLE);
   assign o_command     = command_r;
   assign o_depth       = depth_r;
   assign o_level_valid = level_s;
   assign o_full        = (depth_r == DEPTH_C);
   assign o_empty       = (depth_r == ZERO_C);
   assign o_overflow    = overflow_r;
   assign o_underflow   = underflow_r;

endmodule

// File: doc/regfile_stack_ctrl.md
Name: regfile_stack_ctrl

Overview:
- Sequencer directly upstream of the stacked register-file instances.
- Accepts push/pop requests (interrupt entry/exit) over a valid/ready handshake, tracks nesting depth, and drives a single-cycle Command pulse to every stacked instance.
- Detects overflow/underflow, rejects illegal requests and keeps sticky error flags.
- Provides a thermometer map of occupied stack levels.

Parameters:
- DEPTH, 4, number of stacked register-file levels (legal 1..31).
- DW, $clog2(DEPTH+1), width of depth counter (derived; do not override).

Ports:
- i_clk  input  1  clock
- i_reset  input  1  asynchronous, active-low reset
- i_req_valid  input  1  request present
- i_req_pop  input  1  request type: 0 = push, 1 = pop; sampled with i_req_valid
- o_req_ready  output  1  controller can accept a request this cycle
- o_command  output  Command  per-cycle command to all instances (Command_none / Command_push / Command_pop), from RegFilePkg
- o_depth  output  DW  current nesting depth, 0..DEPTH
- o_level_valid  output  DEPTH  bit k = 1 iff level k holds saved context (k < o_depth)
- o_full  output  1  o_depth == DEPTH
- o_empty  output  1  o_depth == 0
- o_overflow  output  1  sticky: push rejected at full
- o_underflow  output  1  sticky: pop rejected at empty
- i_err_clr  input  1  synchronous clear of both sticky flags

Behaviour:
- Reset (i_reset = 0, asynchronous):
  - state IDLE, o_command = Command_none, o_depth = 0, o_level_valid = 0.
  - o_empty = 1, o_full = 0, o_overflow = 0, o_underflow = 0.
  - Release is synchronous to i_clk.
- FSM states:
  - IDLE: o_req_ready = 1.
  - ISSUE: o_req_ready = 0; o_command holds the registered push/pop for exactly this cycle.
  - Transitions: IDLE -> ISSUE on a legal handshake; ISSUE -> IDLE unconditionally.
- Handshake: a transfer occurs when i_req_valid & o_req_ready at a rising edge. i_req_pop is sampled only then; the requester holds it stable while i_req_valid is high.
- Legal push (accepted, o_depth < DEPTH):
  - Next cycle: state ISSUE, o_command = Command_push.
  - o_depth increments on the same edge that enters ISSUE.
  - o_level_valid[old depth] sets on that same edge.
- Legal pop (accepted, o_depth > 0):
  - Next cycle: o_command = Command_pop.
  - o_depth decrements and o_level_valid[new depth] clears on the same edge.
- Illegal push (depth == DEPTH) or illegal pop (depth == 0):
  - Handshake completes: the request is consumed, not stalled.
  - o_overflow or o_underflow sets on that edge.
  - State stays IDLE; o_command stays Command_none; o_depth unchanged.
- Command pulse:
  - o_command is a registered output and is non-none for exactly one cycle per legal request.
  - Request-to-command latency is 1 cycle.
  - Maximum throughput is one request per 2 cycles.
- Sticky flags:
  - Cleared by i_err_clr at the next edge.
  - If clear and a new error occur in the same cycle, set wins.
  - Errors never block further requests.
- Derived outputs: o_full, o_empty and o_level_valid are pure functions of the registered depth and are always mutually consistent with it.
- Invariants:
  - o_depth never exceeds DEPTH and never wraps below 0.
  - o_level_valid is always thermometer-coded.
- Reset mid-ISSUE: o_command returns to Command_none immediately (asynchronously); depth returns to 0.
- i_req_valid high in ISSUE: ignored (ready = 0); the request is taken in the following IDLE cycle if still valid.

Test Plan:
- Reset, then push x3 (DEPTH=4), back-to-back valid -> o_command = Command_push on cycles 1, 3, 5 after first valid; o_depth 1, 2, 3; o_level_valid 0001, 0011, 0111; o_req_ready low on cycles 1, 3, 5.
- Push to full (4 pushes), then a 5th push -> o_full = 1, o_overflow = 1 on the 5th accept edge, o_command stays Command_none, o_depth = 4; then pop -> Command_pop, o_depth = 3, o_overflow still 1.
- From empty, pop -> o_underflow = 1, no command, o_empty stays 1; assert i_err_clr -> o_underflow = 0 next cycle.
- i_err_clr asserted in the same cycle as an illegal pop at empty -> o_underflow = 1 (set wins).
- Push accepted, then drop i_reset low during the ISSUE cycle -> o_command = Command_none immediately, o_depth = 0, o_level_valid = 0, flags 0; after release a push behaves as from fresh reset.
- Alternate push/pop x8 at depth 2 -> o_depth toggles 3/2, exactly one command pulse per accepted request, no errors.
